// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM request arbiter: bus widths, FSM encoding
// and requester port identifiers.
package sdram_pkg;

  localparam int ADDR_W_DEF = 24;
  localparam int DATA_W_DEF = 16;
  localparam int NUM_PORTS  = 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_RESP      = 2'd3
  } arb_state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. Purely combinational; the caller owns the
// last-grant pointer and decides when to advance it.
module rr_arb2
  import sdram_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 last_grant,
  output logic [NUM_PORTS-1:0] grant
);

  always_comb begin
    grant = '0;
    if (req[PORT_I] && req[PORT_D]) begin
      // Contention: favour whichever port did not win last time.
      grant = port_onehot(~last_grant);
    end else if (req[PORT_I]) begin
      grant = port_onehot(PORT_I);
    end else if (req[PORT_D]) begin
      grant = port_onehot(PORT_D);
    end
  end

endmodule

// File: rtl/sdram_arb.sv
// Merges the instruction-fetch and data ports onto the single SDRAM controller
// request interface, one transaction in flight, round-robin between ports.
module sdram_arb
  import sdram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] c_addr,
  output logic [DATA_W-1:0] c_data_in,
  input  logic [DATA_W-1:0] c_data_out,
  output logic              c_read_req,
  output logic              c_write_req,
  input  logic              c_busy
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic       port_q, port_d;
  logic       we_q, we_d;
  logic       rd_req_q, rd_req_d;
  logic       wr_req_q, wr_req_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic [NUM_PORTS-1:0]             ack_q, ack_d;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rdata_q, rdata_d;

  logic [NUM_PORTS-1:0] req_vec;
  logic [NUM_PORTS-1:0] grant;
  logic                 grant_d_port;
  logic                 grant_we;

  assign req_vec[PORT_I] = i_req;
  assign req_vec[PORT_D] = d_req;

  rr_arb2 u_rr_arb2 (
    .req        (req_vec),
    .last_grant (last_q),
    .grant      (grant)
  );

  assign grant_d_port = grant[PORT_D];
  assign grant_we     = grant_d_port & d_we;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    port_d   = port_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_req_d = rd_req_q;
    wr_req_d = wr_req_q;
    ack_d    = '0;
    rdata_d  = rdata_q;

    case (state_q)
      ST_IDLE: begin
        // A busy controller may be initialising, refreshing or finishing a
        // transaction abandoned by our reset, so never grant while it is busy.
        if (!c_busy && (grant != '0)) begin
          port_d   = grant_d_port;
          addr_d   = grant_d_port ? d_addr : i_addr;
          we_d     = grant_we;
          wdata_d  = grant_d_port ? d_wdata : '0;
          rd_req_d = ~grant_we;
          wr_req_d = grant_we;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (c_busy) begin
          rd_req_d = 1'b0;
          wr_req_d = 1'b0;
          state_d  = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (!c_busy) begin
          ack_d[port_q] = 1'b1;
          if (!we_q) begin
            rdata_d[port_q] = c_data_out;
          end
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        last_d  = port_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pointer resets to the instruction port so the data port wins first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      last_q   <= PORT_I;
      port_q   <= PORT_I;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      ack_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      port_q   <= port_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_req_q <= rd_req_d;
      wr_req_q <= wr_req_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
    end
  end

  assign c_addr      = addr_q;
  assign c_data_in   = wdata_q;
  assign c_read_req  = rd_req_q;
  assign c_write_req = wr_req_q;
  assign i_ack       = ack_q[PORT_I];
  assign d_ack       = ack_q[PORT_D];
  assign i_rdata     = rdata_q[PORT_I];
  assign d_rdata     = rdata_q[PORT_D];

endmodule

// File: tb/tb_sdram_arb.sv
// Randomised bench for sdram_arb: a behavioural controller with a memory, plus a
// transaction-level model of round-robin arbitration and per-port read data.
module tb_sdram_arb;
  import sdram_pkg::*;

  localparam int AW = 24;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_ack;
  logic [DW-1:0] i_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_data_in;
  logic [DW-1:0] c_data_out = '0;
  logic          c_read_req;
  logic          c_write_req;
  logic          c_busy = 1'b0;

  always #5 clk = ~clk;

  sdram_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_ack       (i_ack),
    .i_rdata     (i_rdata),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_ack       (d_ack),
    .d_rdata     (d_rdata),
    .c_addr      (c_addr),
    .c_data_in   (c_data_in),
    .c_data_out  (c_data_out),
    .c_read_req  (c_read_req),
    .c_write_req (c_write_req),
    .c_busy      (c_busy)
  );

  int n_chk = 0;
  int n_pass = 0;
  int txn_n = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return a[15:0] ^ 16'hA5C3;
  endfunction

  // Behavioural controller: raise busy some cycles after a request, hold, then return data.
  bit            ctl_en = 1'b0;
  int            ctl_raise = -1;
  int            ctl_hold = -1;
  logic [DW-1:0] ctl_mem [logic [AW-1:0]];

  initial begin : ctl_model
    logic [AW-1:0] a;
    logic          w;
    logic [DW-1:0] wd;
    int            n;
    forever begin
      @(posedge clk);
      #1;
      if (ctl_en && (c_read_req || c_write_req)) begin
        a  = c_addr;
        w  = c_write_req;
        wd = c_data_in;
        n  = (ctl_raise >= 0) ? ctl_raise : int'($urandom_range(0, 3));
        repeat (n) @(posedge clk);
        #1 c_busy = 1'b1;
        n = (ctl_hold >= 0) ? ctl_hold : int'($urandom_range(1, 6));
        repeat (n) @(posedge clk);
        #1;
        if (w) ctl_mem[a] = wd;
        c_data_out = w ? 16'($urandom) : (ctl_mem.exists(a) ? ctl_mem[a] : dflt(a));
        c_busy = 1'b0;
      end
    end
  end

  // Reference state: what each requester currently asks for, and what the
  // arbiter should do with it.
  bit            pend [2];
  logic [AW-1:0] op_addr [2];
  logic          op_we [2];
  logic [DW-1:0] op_wdata [2];
  logic [DW-1:0] rdata_exp [2];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  bit            last_g;
  int            keep_mode = 2;
  bit            force_chg = 1'b0;
  logic [AW-1:0] force_addr = '0;

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic drive_ports();
    i_req   = pend[0];
    i_addr  = op_addr[0];
    d_req   = pend[1];
    d_we    = op_we[1];
    d_addr  = op_addr[1];
    d_wdata = op_wdata[1];
  endtask

  task automatic new_ops(input int p);
    op_addr[p] = 24'h400000 | AW'($urandom_range(0, 15));
    if (p == 1) begin
      op_we[1]    = 1'($urandom_range(0, 1));
      op_wdata[1] = 16'($urandom);
    end else begin
      op_we[0] = 1'b0;
    end
  endtask

  task automatic model_reset();
    last_g       = PORT_I;
    rdata_exp[0] = '0;
    rdata_exp[1] = '0;
  endtask

  task automatic check_outs(input string tag);
    check_val({tag, "_acks"}, {i_ack, d_ack}, 0);
    check_val({tag, "_creq"}, {c_read_req, c_write_req}, 0);
    check_val({tag, "_caddr"}, c_addr, 0);
    check_val({tag, "_cdin"}, c_data_in, 0);
    check_val({tag, "_rdata"}, {i_rdata, d_rdata}, 0);
  endtask

  // Runs one transaction to completion, starting from a negedge.
  task automatic serve_one(output bit g_obs);
    bit            g;
    bit            seen;
    bit            exp_we;
    bit            keep;
    logic [AW-1:0] a;
    g      = (pend[0] && pend[1]) ? ~last_g : pend[1];
    exp_we = g ? op_we[1] : 1'b0;
    a      = op_addr[g];
    g_obs  = g;
    seen   = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      if (c_read_req || c_write_req) seen = 1'b1;
      else @(negedge clk);
    end
    check_val("issue_seen", seen, 1);
    if (!seen) begin
      pend[g] = 1'b0;
      drive_ports();
      return;
    end
    check_val("c_addr", c_addr, a);
    check_val("c_write_req", c_write_req, exp_we);
    check_val("c_read_req", c_read_req, !exp_we);
    if (exp_we) begin
      check_val("c_data_in", c_data_in, op_wdata[1]);
      ref_mem[a] = op_wdata[1];
    end
    if (pend[!g] && (force_chg || $urandom_range(0, 2) == 0)) begin
      if (force_chg) op_addr[!g] = force_addr;
      else new_ops(int'(!g));
      drive_ports();
    end
    force_chg = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (c_read_req || c_write_req) check_val("c_addr_hold", c_addr, a);
      check_val("rd_wr_excl", c_read_req & c_write_req, 0);
      if (i_ack || d_ack) seen = 1'b1;
    end
    check_val("ack_seen", seen, 1);
    g_obs = d_ack;
    check_val("grant_port", d_ack, g);
    check_val("one_ack", i_ack & d_ack, 0);
    if (!exp_we) rdata_exp[g] = ref_rd(a);
    check_val("i_rdata", i_rdata, rdata_exp[0]);
    check_val("d_rdata", d_rdata, rdata_exp[1]);
    txn_n++;
    $display("txn %0d port=%s we=%0d addr=%06h i_rdata=%04h d_rdata=%04h",
             txn_n, g ? "D" : "I", exp_we, a, i_rdata, d_rdata);
    last_g = g;
    keep = (keep_mode == 1) || (keep_mode == 0 && $urandom_range(0, 2) == 0);
    if (keep) new_ops(int'(g));
    else pend[g] = 1'b0;
    drive_ports();
    @(negedge clk);
    check_val("ack_pulse", {i_ack, d_ack}, 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin : stim
    bit            g;
    bit            seen;
    logic [DW-1:0] prev;
    pend[0] = 0; pend[1] = 0;
    op_we[0] = 0; op_we[1] = 0;
    op_wdata[0] = '0; op_wdata[1] = '0;
    op_addr[0] = '0; op_addr[1] = '0;
    model_reset();

    // Reset with controller busy and a fetch already pending.
    c_busy = 1'b1;
    pend[0] = 1'b1;
    op_addr[0] = 24'h000777;
    drive_ports();
    repeat (2) @(negedge clk);
    check_outs("rst");
    rst_n = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      check_val("busy_hold_off", c_read_req, 0);
    end
    c_busy = 1'b0;
    @(negedge clk);
    check_val("t1_read_req", c_read_req, 1);
    check_val("t1_addr", c_addr, 24'h000777);
    ctl_en = 1'b1;
    serve_one(g);

    // Fetch with fixed controller timing.
    ctl_raise = 2;
    ctl_hold  = 6;
    ctl_mem[24'h000123] = 16'hBEEF;
    ref_mem[24'h000123] = 16'hBEEF;
    pend[0] = 1'b1;
    op_addr[0] = 24'h000123;
    drive_ports();
    serve_one(g);
    check_val("t2_port", g, 0);
    check_val("t2_i_rdata", i_rdata, 16'hBEEF);
    ctl_raise = -1;
    ctl_hold  = -1;

    // Data write.
    prev = d_rdata;
    pend[1] = 1'b1;
    op_we[1] = 1'b1;
    op_addr[1] = 24'h400010;
    op_wdata[1] = 16'h55AA;
    drive_ports();
    serve_one(g);
    check_val("t3_port", g, 1);
    check_val("t3_d_rdata_kept", d_rdata, prev);
    check_val("t3_i_rdata_kept", i_rdata, 16'hBEEF);

    // Data operands change while an instruction fetch is in flight.
    pend[0] = 1'b1;
    op_addr[0] = 24'h000200;
    pend[1] = 1'b1;
    op_we[1] = 1'b0;
    op_addr[1] = 24'h000001;
    drive_ports();
    force_chg = 1'b1;
    force_addr = 24'h000002;
    serve_one(g);
    check_val("t5_first", g, 0);
    serve_one(g);
    check_val("t5_second", g, 1);
    check_val("t5_d_rdata", d_rdata, dflt(24'h000002));

    // Continuous contention after reset: D first, then strict alternation.
    rst_n = 1'b0;
    @(negedge clk);
    check_outs("rst2");
    rst_n = 1'b1;
    model_reset();
    new_ops(0);
    new_ops(1);
    op_addr[0] = 24'h100000 | AW'($urandom_range(0, 15));
    pend[0] = 1'b1;
    pend[1] = 1'b1;
    drive_ports();
    keep_mode = 1;
    for (int k = 0; k < 6; k++) begin
      serve_one(g);
      check_val("t4_order", g, (k % 2 == 0) ? 1 : 0);
    end

    // Random traffic.
    keep_mode = 0;
    for (int s = 0; s < 40; s++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 1) == 1) begin
          new_ops(p);
          pend[p] = 1'b1;
        end
      end
      if (!pend[0] && !pend[1]) begin
        pend[s % 2] = 1'b1;
        new_ops(s % 2);
      end
      drive_ports();
      serve_one(g);
    end
    keep_mode = 2;
    for (int k = 0; k < 3 && (pend[0] || pend[1]); k++) serve_one(g);

    // Asynchronous reset while waiting for the controller to finish.
    ctl_raise = 0;
    ctl_hold  = 8;
    new_ops(0);
    pend[0] = 1'b1;
    drive_ports();
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (c_busy && !c_read_req && !c_write_req) seen = 1'b1;
    end
    check_val("t6_wait_done", seen, 1);
    #2 rst_n = 1'b0;
    #1 check_outs("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    check_val("t6_busy_still", c_busy, 1);
    for (int k = 0; k < 60 && c_busy; k++) begin
      check_val("t6_no_grant_busy", c_read_req, 0);
      @(negedge clk);
    end
    ctl_raise = -1;
    ctl_hold  = -1;
    serve_one(g);
    check_val("t6_port", g, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
